project_pwm_peripheral_action_unit: RTL and testbench
=====================================================

Name: project_pwm_peripheral_action_unit

Overview:
Parametrised successor to the single-output PWM comparator. It compares a shared time-base counter against NUM_CMP compare channels, plus zero and period, and applies direction-aware actions to a raw PWM level. It adds shadow-buffered compare values, software force, and a complementary output pair with independent rising/falling dead-time. It sits between the time-base counter and the pad muxes of the PWM peripheral.

Parameters:
WIDTH, 16, counter/period/compare width in bits
NUM_CMP, 2, number of compare channels (1..8)
DT_WIDTH, 8, dead-time counter width in bits

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_enable  in  1  1 = outputs driven per FSM; 0 = both outputs low, FSM to ST_IDLE
i_period  in  WIDTH  period value
i_counter  in  WIDTH  current counter value
i_counter_next  in  WIDTH  value the counter takes at the next edge
i_dir_next  in  1  counting direction for i_counter_next: 1 = up, 0 = down
i_compare  in  NUM_CMP*WIDTH  compare values, channel k at [k*WIDTH +: WIDTH] (shadow input)
i_action_zero  in  2  action on zero
i_action_period  in  2  action on period
i_action_cmp_up  in  NUM_CMP*2  per-channel action on a compare match while counting up
i_action_cmp_down  in  NUM_CMP*2  per-channel action on a compare match while counting down
i_load_mode  in  2  shadow load: 00 immediate, 01 on zero, 10 on period, 11 on zero or period
i_force_en  in  1  force raw level
i_force_val  in  1  forced raw level
i_deadtime_rise  in  DT_WIDTH  cycles both outputs stay low before o_pwm_a rises
i_deadtime_fall  in  DT_WIDTH  cycles both outputs stay low before o_pwm_b rises
o_pwm_a  out  1  high-side output
o_pwm_b  out  1  low-side (complementary) output
o_raw  out  1  raw PWM level before dead-time
o_event_zero  out  1  one-cycle pulse
o_event_period  out  1  one-cycle pulse
o_event_cmp  out  NUM_CMP  one-cycle pulse per channel

Behaviour:
- Reset (async): r_raw=0, active compares=0, all events=0, FSM=ST_IDLE, o_pwm_a=o_pwm_b=0, dead-time counter=0.
- Action encoding: 00 nothing, 01 clear, 10 set, 11 toggle.
- Matches are evaluated on i_counter_next. The event registers and r_raw update at the same edge the counter takes that value, so o_raw and o_event_* align with i_counter.
- Priority when several values match: zero > cmp[0] > cmp[1] > ... > cmp[NUM_CMP-1] > period. Only the highest-priority match drives the action. Every matching event still pulses.
- Compare action is selected by i_dir_next: up uses i_action_cmp_up[k], down uses i_action_cmp_down[k].
- i_force_en=1: r_raw <= i_force_val each cycle. Events still pulse; actions are ignored.
- Shadow load:
  - Active compare values load from i_compare at the edge where the selected load event (on i_counter_next) occurs.
  - The match at that same edge uses the old active values.
  - Mode 00: active <= i_compare every cycle (one-cycle latency).
- Equal compare values across channels: the lower index wins the action. Both event bits pulse.
- Dead-time FSM states: ST_IDLE (a=0,b=0), ST_A (a=1,b=0), ST_DT_A (0,0, counting toward A), ST_B (a=0,b=1), ST_DT_B (0,0, counting toward B).
  - ST_IDLE with i_enable=1: go to ST_DT_A if r_raw=1, else ST_DT_B; load the counter with the matching dead-time.
  - ST_A with r_raw=0: go to ST_DT_B, count=i_deadtime_fall.
  - ST_B with r_raw=1: go to ST_DT_A, count=i_deadtime_rise.
  - ST_DT_x: decrement each cycle; enter ST_x when count==0 at the check.
  - Dead-time 0 means the transition happens one cycle after the r_raw change.
  - r_raw reverses during a dead phase: switch to the opposite dead state and reload that state's dead-time. Outputs stay 0, and a and b are never both 1.
- Latency: o_pwm_a/o_pwm_b change 1 + deadtime cycles after o_raw.
- i_enable=0 at any time: FSM goes to ST_IDLE next edge and both outputs go low. r_raw and events keep updating.
- Period matched while i_period==0 is treated as a zero match (zero wins).

Test Plan:
- Up-count 0..9, period=9, cmp0=4 up=clear, zero=set, dt=0 -> o_raw high for counter 0..3, low for 4..9; o_pwm_b = ~o_raw delayed by 1 cycle.
- Up-down 0..8..0, cmp0=3, up=set, down=clear, zero=clear -> o_raw high for counter 3 up through 3 down (exclusive); o_event_cmp[0] pulses twice per cycle.
- cmp0=cmp1=5, actions set/clear -> o_raw set at 5; both o_event_cmp bits pulse.
- Load mode 01, change i_compare 4->7 mid-period -> match stays at 4 until the counter wraps to 0, then 7.
- dt_rise=3, dt_fall=2, o_raw 0->1 -> o_pwm_b falls after 1 cycle, o_pwm_a rises 4 cycles after o_raw. If o_raw returns to 0 within 2 cycles -> o_pwm_a never rises and o_pwm_b re-asserts after 2+1 cycles.
- Assert i_reset while o_pwm_a=1 -> both outputs 0 immediately. i_force_en=1, val=1 -> o_raw=1 next edge regardless of matches.

Source files
------------

// File: rtl/project_pwm_peripheral_action_unit.sv
`default_nettype none
// ============================================================================
// project_pwm_peripheral_action_unit
//   Compare/action stage with shadowed compares and a complementary dead-time output pair.
//   Revision: 1.0
// ============================================================================
module project_pwm_peripheral_action_unit #(
  parameter int WIDTH    = 16,
  parameter int NUM_CMP  = 2,
  parameter int DT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [WIDTH-1:0]           i_period,
  input  logic [WIDTH-1:0]           i_counter,
  input  logic [WIDTH-1:0]           i_counter_next,
  input  logic                       i_dir_next,
  input  logic [NUM_CMP*WIDTH-1:0]   i_compare,
  input  logic [1:0]                 i_action_zero,
  input  logic [1:0]                 i_action_period,
  input  logic [NUM_CMP*2-1:0]       i_action_cmp_up,
  input  logic [NUM_CMP*2-1:0]       i_action_cmp_down,
  input  logic [1:0]                 i_load_mode,
  input  logic                       i_force_en,
  input  logic                       i_force_val,
  input  logic [DT_WIDTH-1:0]        i_deadtime_rise,
  input  logic [DT_WIDTH-1:0]        i_deadtime_fall,
  output logic                       o_pwm_a,
  output logic                       o_pwm_b,
  output logic                       o_raw,
  output logic                       o_event_zero,
  output logic                       o_event_period,
  output logic [NUM_CMP-1:0]         o_event_cmp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A    = 3'd1,
    ST_DT_A = 3'd2,
    ST_B    = 3'd3,
    ST_DT_B = 3'd4
  } state_t;

  localparam logic [1:0]          c_ACT_CLR = 2'b01;
  localparam logic [1:0]          c_ACT_SET = 2'b10;
  localparam logic [1:0]          c_ACT_TGL = 2'b11;
  localparam logic [DT_WIDTH-1:0] c_DT_ONE  = DT_WIDTH'(1);

  logic [NUM_CMP*WIDTH-1:0] r_cmp_active;
  logic                     r_raw;
  logic                     r_ev_zero;
  logic                     r_ev_period;
  logic [NUM_CMP-1:0]       r_ev_cmp;
  state_t                   r_state;
  logic [DT_WIDTH-1:0]      r_dt_cnt;

  logic                     w_match_zero;
  logic                     w_match_period;
  logic [NUM_CMP-1:0]       w_match_cmp;
  logic [1:0]               w_action;
  logic                     w_raw_next;
  logic                     w_load;
  state_t                   w_state_next;
  logic [DT_WIDTH-1:0]      w_dt_cnt_next;
  logic                     w_go_a;
  logic                     w_go_b;
  logic                     w_unused;

  // Matching is done one step ahead on i_counter_next; the current count is not needed.
  assign w_unused       = ^i_counter;
  assign w_match_zero   = (i_counter_next == '0);
  assign w_match_period = (i_counter_next == i_period);

  generate
    for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp_match
      assign w_match_cmp[g] = (i_counter_next == r_cmp_active[g*WIDTH +: WIDTH]);
    end
  endgenerate

  // Lowest priority is written first so higher-priority matches overwrite it.
  always_comb begin
    w_action = 2'b00;
    if (w_match_period) w_action = i_action_period;
    for (int k = NUM_CMP - 1; k >= 0; k--) begin
      if (w_match_cmp[k])
        w_action = i_dir_next ? i_action_cmp_up[k*2 +: 2] : i_action_cmp_down[k*2 +: 2];
    end
    if (w_match_zero) w_action = i_action_zero;
  end

  always_comb begin
    w_raw_next = r_raw;
    if (i_force_en) begin
      w_raw_next = i_force_val;
    end else begin
      case (w_action)
        c_ACT_CLR: w_raw_next = 1'b0;
        c_ACT_SET: w_raw_next = 1'b1;
        c_ACT_TGL: w_raw_next = ~r_raw;
        default:   w_raw_next = r_raw;
      endcase
    end
  end

  always_comb begin
    w_load = 1'b1;
    case (i_load_mode)
      2'b01:   w_load = w_match_zero;
      2'b10:   w_load = w_match_period;
      2'b11:   w_load = w_match_zero | w_match_period;
      default: w_load = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cmp_active <= '0;
      r_raw        <= 1'b0;
      r_ev_zero    <= 1'b0;
      r_ev_period  <= 1'b0;
      r_ev_cmp     <= '0;
    end else begin
      if (w_load) r_cmp_active <= i_compare;
      r_raw       <= w_raw_next;
      r_ev_zero   <= w_match_zero;
      r_ev_period <= w_match_period;
      r_ev_cmp    <= w_match_cmp;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_dt_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_dt_cnt <= w_dt_cnt_next;
    end
  end

  // The dead counter holds the low cycles still owed, so a zero dead-time skips the dead state.
  always_comb begin
    w_state_next  = r_state;
    w_dt_cnt_next = r_dt_cnt;
    w_go_a        = 1'b0;
    w_go_b        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_go_a = r_raw;
        w_go_b = ~r_raw;
      end
      ST_A: w_go_b = ~r_raw;
      ST_B: w_go_a = r_raw;
      ST_DT_A: begin
        if (!r_raw)                   w_go_b = 1'b1;
        else if (r_dt_cnt <= c_DT_ONE) w_state_next = ST_A;
        else                          w_dt_cnt_next = r_dt_cnt - c_DT_ONE;
      end
      ST_DT_B: begin
        if (r_raw)                    w_go_a = 1'b1;
        else if (r_dt_cnt <= c_DT_ONE) w_state_next = ST_B;
        else                          w_dt_cnt_next = r_dt_cnt - c_DT_ONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_go_a) begin
      w_state_next  = (i_deadtime_rise == '0) ? ST_A : ST_DT_A;
      w_dt_cnt_next = i_deadtime_rise;
    end
    if (w_go_b) begin
      w_state_next  = (i_deadtime_fall == '0) ? ST_B : ST_DT_B;
      w_dt_cnt_next = i_deadtime_fall;
    end
    if (!i_enable) begin
      w_state_next  = ST_IDLE;
      w_dt_cnt_next = '0;
    end
  end

  assign o_pwm_a        = (r_state == ST_A) & i_enable;
  assign o_pwm_b        = (r_state == ST_B) & i_enable;
  assign o_raw          = r_raw;
  assign o_event_zero   = r_ev_zero;
  assign o_event_period = r_ev_period;
  assign o_event_cmp    = r_ev_cmp;

endmodule
`default_nettype wire

// File: tb/tb_project_pwm_peripheral_action_unit.sv
`default_nettype none
// ============================================================================
// tb_project_pwm_peripheral_action_unit
//   Randomized bench checked against a behavioural model of the action unit.
//   Revision: 1.0
// ============================================================================
module tb_project_pwm_peripheral_action_unit;
  localparam int WIDTH    = 16;
  localparam int NUM_CMP  = 2;
  localparam int DT_WIDTH = 8;
  localparam int HIST     = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     en = 1'b0;
  logic [WIDTH-1:0]         period = '0;
  logic [WIDTH-1:0]         cnt = '0;
  logic [WIDTH-1:0]         cnt_next = '0;
  logic                     dir_next = 1'b1;
  logic [NUM_CMP*WIDTH-1:0] cmp = '0;
  logic [1:0]               a_zero = '0;
  logic [1:0]               a_per = '0;
  logic [NUM_CMP*2-1:0]     a_up = '0;
  logic [NUM_CMP*2-1:0]     a_dn = '0;
  logic [1:0]               lmode = '0;
  logic                     fen = 1'b0;
  logic                     fval = 1'b0;
  logic [DT_WIDTH-1:0]      dtr = '0;
  logic [DT_WIDTH-1:0]      dtf = '0;
  logic                     pwm_a, pwm_b, raw, ev_z, ev_p;
  logic [NUM_CMP-1:0]       ev_c;

  project_pwm_peripheral_action_unit #(
    .WIDTH(WIDTH), .NUM_CMP(NUM_CMP), .DT_WIDTH(DT_WIDTH)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_period(period),
    .i_counter(cnt), .i_counter_next(cnt_next), .i_dir_next(dir_next),
    .i_compare(cmp), .i_action_zero(a_zero), .i_action_period(a_per),
    .i_action_cmp_up(a_up), .i_action_cmp_down(a_dn), .i_load_mode(lmode),
    .i_force_en(fen), .i_force_val(fval),
    .i_deadtime_rise(dtr), .i_deadtime_fall(dtf),
    .o_pwm_a(pwm_a), .o_pwm_b(pwm_b), .o_raw(raw),
    .o_event_zero(ev_z), .o_event_period(ev_p), .o_event_cmp(ev_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic                 m_raw = 1'b0;
  logic                 m_ev_z = 1'b0;
  logic                 m_ev_p = 1'b0;
  logic [NUM_CMP-1:0]   m_ev_c = '0;
  logic [WIDTH-1:0]     m_act [NUM_CMP];
  bit                   raw_h [HIST];
  bit                   en_h  [HIST];
  int                   edge_n = -1;

  // Time-base generator
  int tb_cnt = 0;
  bit tb_up = 1'b1;
  bit updown = 1'b0;
  int tb_nxt = 0;
  bit tb_dn = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_raw = 1'b0; m_ev_z = 1'b0; m_ev_p = 1'b0; m_ev_c = '0;
    for (int k = 0; k < NUM_CMP; k++) m_act[k] = '0;
  endtask

  task automatic model_edge();
    logic zero, per, ld;
    logic [NUM_CMP-1:0] cm;
    logic [1:0] act;
    bit found;
    if (rst) begin
      model_reset();
      return;
    end
    zero = (cnt_next == 0);
    per  = (cnt_next == period);
    for (int k = 0; k < NUM_CMP; k++) cm[k] = (cnt_next == m_act[k]);
    m_ev_z = zero; m_ev_p = per; m_ev_c = cm;
    act = 2'b00;
    found = zero;
    if (zero) act = a_zero;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (!found && cm[k]) begin
        found = 1'b1;
        act = dir_next ? a_up[2*k +: 2] : a_dn[2*k +: 2];
      end
    end
    if (!found && per) act = a_per;
    if (fen) m_raw = fval;
    else if (act == 2'b01) m_raw = 1'b0;
    else if (act == 2'b10) m_raw = 1'b1;
    else if (act == 2'b11) m_raw = !m_raw;
    case (lmode)
      2'b00:   ld = 1'b1;
      2'b01:   ld = zero;
      2'b10:   ld = per;
      default: ld = zero || per;
    endcase
    if (ld) for (int k = 0; k < NUM_CMP; k++) m_act[k] = cmp[k*WIDTH +: WIDTH];
  endtask

  // An output is on once raw has held its level, enabled, for the last 1+dead-time edges.
  function automatic bit held(input bit lvl, input int d);
    for (int k = 0; k <= d; k++) begin
      if (edge_n - k < 0) return 1'b0;
      if (!en_h[edge_n - k] || raw_h[edge_n - k] != lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive_timebase();
    if (!updown) begin
      tb_nxt = (tb_cnt >= int'(period)) ? 0 : tb_cnt + 1; tb_dn = 1'b1;
    end else if (tb_up) begin
      if (tb_cnt >= int'(period)) begin tb_nxt = tb_cnt - 1; tb_dn = 1'b0; end
      else begin tb_nxt = tb_cnt + 1; tb_dn = 1'b1; end
    end else begin
      if (tb_cnt == 0) begin tb_nxt = 1; tb_dn = 1'b1; end
      else begin tb_nxt = tb_cnt - 1; tb_dn = 1'b0; end
    end
    cnt = WIDTH'(tb_cnt); cnt_next = WIDTH'(tb_nxt); dir_next = tb_dn;
  endtask

  task automatic step();
    bit exp_a, exp_b;
    drive_timebase();
    @(posedge clk);
    edge_n++;
    raw_h[edge_n] = m_raw;
    en_h[edge_n]  = en && !rst;
    model_edge();
    tb_cnt = tb_nxt; tb_up = tb_dn;
    @(negedge clk);
    exp_a = en && !rst && held(1'b1, int'(dtr));
    exp_b = en && !rst && held(1'b0, int'(dtf));
    check_val("raw",      32'(raw),   32'(m_raw));
    check_val("ev_zero",  32'(ev_z),  32'(m_ev_z));
    check_val("ev_period",32'(ev_p),  32'(m_ev_p));
    check_val("ev_cmp",   32'(ev_c),  32'(m_ev_c));
    check_val("pwm_a",    32'(pwm_a), 32'(exp_a));
    check_val("pwm_b",    32'(pwm_b), 32'(exp_b));
  endtask

  task automatic setup(input int per, input bit ud, input logic [1:0] az, input logic [1:0] ap,
                       input logic [3:0] up, input logic [3:0] dn, input int c0, input int c1,
                       input logic [1:0] lm);
    period = WIDTH'(per); updown = ud; a_zero = az; a_per = ap;
    a_up = up; a_dn = dn; lmode = lm;
    cmp = {WIDTH'(c1), WIDTH'(c0)};
    tb_cnt = 0; tb_up = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int force_seq [14] = '{0, 6, 1, 8, 0, 8, 1, 2, 0, 8, 1, 1, 0, 6};

  initial begin
    model_reset();
    // Reset state
    run(3);
    rst = 1'b0;
    en = 1'b1;
    // Up-count, cmp0 clears, zero sets, no dead-time
    setup(9, 1'b0, 2'b10, 2'b00, 4'b0001, 4'b0000, 4, 16'hFFFF, 2'b00);
    run(40);
    // Up-down, cmp0 sets going up and clears going down
    setup(8, 1'b1, 2'b01, 2'b00, 4'b0010, 4'b0001, 3, 16'hFFFF, 2'b00);
    run(50);
    // Equal compares: channel 0 sets, channel 1 clears
    setup(9, 1'b0, 2'b01, 2'b00, 4'b0110, 4'b0000, 5, 5, 2'b00);
    run(30);
    // Shadow load on zero, compare changed mid-period
    setup(9, 1'b0, 2'b10, 2'b00, 4'b0001, 4'b0000, 4, 16'hFFFF, 2'b01);
    run(14);
    cmp[WIDTH-1:0] = 16'd7;
    run(26);
    // Asymmetric dead-time with forced raw pulses, including a short one
    en = 1'b0; dtr = 8'd3; dtf = 8'd2;
    run(1);
    en = 1'b1; fen = 1'b1;
    for (int i = 0; i < 14; i += 2) begin
      fval = force_seq[i][0];
      run(force_seq[i+1]);
    end
    // Reset while high side is on
    en = 1'b0; dtr = '0; dtf = '0;
    run(1);
    en = 1'b1; fval = 1'b1;
    run(4);
    rst = 1'b1;
    #1;
    check_val("rst_async_pwm_a", 32'(pwm_a), 32'd0);
    check_val("rst_async_pwm_b", 32'(pwm_b), 32'd0);
    check_val("rst_async_raw",   32'(raw),   32'd0);
    run(2);
    rst = 1'b0; fen = 1'b0;
    run(4);
    // Randomized phases
    for (int ph = 0; ph < 30; ph++) begin
      en = 1'b0;
      dtr = DT_WIDTH'($urandom_range(6, 0));
      dtf = DT_WIDTH'($urandom_range(6, 0));
      begin
        int p;
        p = $urandom_range(20, 2);
        setup(p, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
              4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
              $urandom_range(p + 1, 0), $urandom_range(p + 1, 0), 2'($urandom_range(3, 0)));
      end
      run(1);
      en = 1'b1;
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(99, 0) < 6)
          cmp[($urandom_range(NUM_CMP - 1, 0))*WIDTH +: WIDTH] = WIDTH'($urandom_range(int'(period) + 1, 0));
        if ($urandom_range(99, 0) < 4) fen = !fen;
        fval = 1'($urandom_range(1, 0));
        if ($urandom_range(99, 0) < 3) en = 1'b0;
        else if (!en && $urandom_range(99, 0) < 30) en = 1'b1;
        rst = ($urandom_range(99, 0) < 2);
        step();
      end
      rst = 1'b0; fen = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
